// File: rtl/icache_axi_rd_bridge_pkg.sv
// rtl/icache_axi_rd_bridge_pkg.sv - shared constants, state encoding and helpers for the icache AXI read bridge
package icache_axi_rd_bridge_pkg;

   // Line geometry shared with inst_cache: 32-byte lines, 8 words per line.
   localparam int IC_LINE_OFFSET_WIDTH = 5;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } br_state_e;

   // Clear the byte-offset bits so a refill always starts at the line base.
   function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned ofs_w);
      logic [31:0] mask;
      mask = ~((32'h1 << ofs_w) - 32'h1);
      return addr & mask;
   endfunction

endpackage

// File: rtl/icache_axi_rd_bridge_beat_ctr.sv
// rtl/icache_axi_rd_bridge_beat_ctr.sv - R-channel beat counter with last-beat compare against arlen
module icache_axi_beat_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       inc_i,
   input  logic [7:0] len_i,
   output logic [7:0] beat_o,
   output logic       last_o
);

   logic [7:0] beat_q;
   logic [7:0] beat_d;

   assign beat_o = beat_q;
   assign last_o = (beat_q == len_i);

   // Next count: clear on a new transaction, otherwise advance and wrap on the last beat.
   always_comb begin
      beat_d = beat_q;
      if (clr_i) begin
         beat_d = 8'd0;
      end else if (inc_i) begin
         beat_d = last_o ? 8'd0 : beat_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q <= 8'd0;
      end else begin
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// rtl/icache_axi_rd_bridge.sv - inst_cache refill/uncached read requests to an AXI4 AR/R channel pair
module icache_axi_rd_bridge
   import icache_axi_rd_bridge_pkg::*;
#(
   parameter int              ID_W              = 4,
   parameter logic [ID_W-1:0] AR_ID             = '0,
   parameter int              LINE_OFFSET_WIDTH = IC_LINE_OFFSET_WIDTH,
   parameter int              LINE_WORDS        = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cache_ena,
   input  logic            flush,
   input  logic [31:0]     c_araddr,
   input  logic            c_arvalid,
   output logic            c_arready,
   output logic [31:0]     c_rdata,
   output logic            c_rvalid,
   output logic            c_rlast,
   input  logic            c_rready,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   output logic            err
);

   localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

   br_state_e   state_q,     state_d;
   logic [31:0] araddr_q,    araddr_d;
   logic [7:0]  arlen_q,     arlen_d;
   logic [1:0]  arburst_q,   arburst_d;
   logic        c_arready_q, c_arready_d;
   logic        discard_q,   discard_d;
   logic        err_q,       err_d;

   logic        beat_clr;
   logic        beat_last;
   logic [7:0]  beat;
   logic        r_hs;

   // The R channel ID is not used: exactly one transaction is ever outstanding.
   logic        unused_rid;
   assign unused_rid = ^rid;

   assign arid      = AR_ID;
   assign arsize    = AXI_SIZE_4B;
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arburst   = arburst_q;
   assign arvalid   = (state_q == ST_ADDR);
   assign c_arready = c_arready_q;
   assign err       = err_q;
   assign c_rdata   = rdata;
   assign c_rlast   = c_rvalid & beat_last;
   assign r_hs      = rvalid & rready;

   icache_axi_beat_ctr u_beat_ctr (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (beat_clr),
      .inc_i  (r_hs),
      .len_i  (arlen_q),
      .beat_o (beat),
      .last_o (beat_last)
   );

   // R-channel pass-through: beats are only visible to the cache in DATA and
   // while not discarding; a discarded burst is drained at full rate.
   always_comb begin
      c_rvalid = 1'b0;
      rready   = 1'b0;
      if (state_q == ST_DATA) begin
         c_rvalid = rvalid & ~discard_q;
         rready   = discard_q | c_rready;
      end
   end

   // Next-state and register updates for the request/address/data sequence.
   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      arburst_d   = arburst_q;
      c_arready_d = 1'b0;
      discard_d   = discard_q;
      err_d       = err_q;
      beat_clr    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A request arriving together with a flush belongs to the squashed path.
            if (c_arvalid && !flush) begin
               if (cache_ena) begin
                  araddr_d = line_align(c_araddr, LINE_OFFSET_WIDTH);
                  arlen_d  = LINE_LEN;
               end else begin
                  araddr_d = c_araddr;
                  arlen_d  = 8'd0;
               end
               arburst_d   = AXI_BURST_INCR;
               c_arready_d = 1'b1;
               discard_d   = 1'b0;
               beat_clr    = 1'b1;
               state_d     = ST_ADDR;
            end
         end

         ST_ADDR: begin
            // AXI forbids retracting arvalid, so a flush here only marks the data for discard.
            if (flush) begin
               discard_d = 1'b1;
            end
            if (arready) begin
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (flush) begin
               discard_d = 1'b1;
            end
            if (r_hs) begin
               if (rresp != AXI_RESP_OKAY) begin
                  err_d = 1'b1;
               end
               if (rlast) begin
                  // The interconnect's rlast always closes the transaction; early rlast is an error.
                  if (!beat_last) begin
                     err_d = 1'b1;
                  end
                  discard_d = 1'b0;
                  beat_clr  = 1'b1;
                  state_d   = ST_IDLE;
               end else if (beat_last) begin
                  // Burst overrun: keep draining until rlast, hiding the extra beats from the cache.
                  err_d     = 1'b1;
                  discard_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         araddr_q    <= 32'd0;
         arlen_q     <= 8'd0;
         arburst_q   <= 2'b00;
         c_arready_q <= 1'b0;
         discard_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         arburst_q   <= arburst_d;
         c_arready_q <= c_arready_d;
         discard_q   <= discard_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// tb/tb_icache_axi_rd_bridge.sv - scoreboard testbench for icache_axi_rd_bridge
module tb_icache_axi_rd_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cache_ena = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] c_araddr = 32'd0;
   logic        c_arvalid = 1'b0;
   logic        c_arready;
   logic [31:0] c_rdata;
   logic        c_rvalid;
   logic        c_rlast;
   logic        c_rready = 1'b1;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [3:0]  rid = 4'h5;
   logic [31:0] rdata = 32'd0;
   logic [1:0]  rresp = 2'b00;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        err;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
   } ar_t;

   beat_t sb_q[$];
   ar_t   ar_q[$];

   icache_axi_rd_bridge #(
      .ID_W (4),
      .AR_ID (4'h0),
      .LINE_OFFSET_WIDTH (5),
      .LINE_WORDS (8)
   ) dut (
      .clk (clk), .rst (rst), .cache_ena (cache_ena), .flush (flush),
      .c_araddr (c_araddr), .c_arvalid (c_arvalid), .c_arready (c_arready),
      .c_rdata (c_rdata), .c_rvalid (c_rvalid), .c_rlast (c_rlast), .c_rready (c_rready),
      .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize), .arburst (arburst),
      .arvalid (arvalid), .arready (arready),
      .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready),
      .err (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every beat handed to the cache must match the next expected beat.
   always @(negedge clk) begin
      if (!rst && c_rvalid === 1'b1 && c_rready === 1'b1) begin
         if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_beat: got data %h last %b with nothing expected", c_rdata, c_rlast);
         end else begin
            beat_t e;
            e = sb_q.pop_front();
            check("beat_data", c_rdata, e.data);
            check("beat_last", c_rlast, e.last);
         end
      end
   end

   // Monitor: every AR handshake must match the next expected address phase.
   always @(negedge clk) begin
      if (!rst && arvalid === 1'b1 && arready === 1'b1) begin
         if (ar_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_ar: got addr %h len %0d with nothing expected", araddr, arlen);
         end else begin
            ar_t e;
            e = ar_q.pop_front();
            check("ar_fields", {araddr, arlen, arsize, arburst, arid}, e);
         end
      end
   end

   // Issue a request and complete its AR phase after 'stall' cycles of arready low.
   task automatic issue(input logic [31:0] addr, input logic ena, input logic [31:0] exp_addr,
                        input logic [7:0] exp_len, input int stall);
      c_arvalid = 1'b1;
      c_araddr  = addr;
      cache_ena = ena;
      @(posedge clk); #1;
      c_arvalid = 1'b0;
      check("c_arready_pulse", c_arready, 1'b1);
      ar_q.push_back('{exp_addr, exp_len, 3'b010, 2'b01, 4'h0});
      for (int k = 0; k < stall; k++) begin
         check("arvalid_hold", arvalid, 1'b1);
         check("araddr_hold", araddr, exp_addr);
         check("arlen_hold", arlen, exp_len);
         @(posedge clk); #1;
         check("c_arready_low", c_arready, 1'b0);
      end
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      check("arvalid_drop", arvalid, 1'b0);
   endtask

   // Drive n R beats; rlast on index last_at, flush on index flush_at, SLVERR on index bad_idx.
   task automatic beats(input int n, input logic [31:0] base, input logic [7:0] len,
                        input int last_at, input int flush_at, input int bad_idx);
      for (int i = 0; i < n; i++) begin
         rvalid = 1'b1;
         rdata  = base + 32'(4 * i);
         rlast  = (i == last_at);
         rresp  = (i == bad_idx) ? 2'b10 : 2'b00;
         flush  = (i == flush_at);
         if (flush_at >= 0 && i > flush_at) begin
            c_rready = 1'b0;
            #1;
            check("discard_c_rvalid", c_rvalid, 1'b0);
            check("discard_rready", rready, 1'b1);
         end else begin
            c_rready = 1'b1;
            sb_q.push_back('{base + 32'(4 * i), (i == int'(len))});
         end
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0; flush = 1'b0; rresp = 2'b00; c_rready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_c_arready", c_arready, 1'b0);
      check("rst_c_rvalid", c_rvalid, 1'b0);
      check("rst_c_rlast", c_rlast, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_ar_fields", {araddr, arlen, arburst, arid, arsize}, {32'd0, 8'd0, 2'b00, 4'h0, 3'b010});
      rst = 1'b0;
      @(posedge clk); #1;

      // Cached refill, line-aligned address, 8 beats.
      issue(32'hF000_0014, 1'b1, 32'hF000_0000, 8'd7, 0);
      beats(8, 32'hF000_0000, 8'd7, 7, -1, -1);
      check("cached_err", err, 1'b0);

      // Uncached single-word read right after the previous burst.
      issue(32'h0200_000C, 1'b0, 32'h0200_000C, 8'd0, 0);
      beats(1, 32'h0200_000C, 8'd0, 0, -1, -1);

      // arready stalled 3 cycles.
      issue(32'h1234_5678, 1'b1, 32'h1234_5660, 8'd7, 3);
      beats(8, 32'h1234_5660, 8'd7, 7, -1, -1);

      // Request coinciding with flush in IDLE is ignored.
      c_arvalid = 1'b1; c_araddr = 32'h0000_0080; cache_ena = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      c_arvalid = 1'b0; flush = 1'b0;
      check("flush_idle_c_arready", c_arready, 1'b0);
      check("flush_idle_arvalid", arvalid, 1'b0);

      // Flush during beat 3 of a refill, then a normal request.
      issue(32'h0000_0040, 1'b1, 32'h0000_0040, 8'd7, 0);
      beats(8, 32'h0000_0040, 8'd7, 7, 2, -1);
      check("flush_err", err, 1'b0);
      issue(32'h0000_0100, 1'b0, 32'h0000_0100, 8'd0, 0);
      beats(1, 32'h0000_0100, 8'd0, 0, -1, -1);

      // Early rlast on beat 6 of 8: sticky error, bridge still serves the next request.
      issue(32'h0000_0200, 1'b1, 32'h0000_0200, 8'd7, 0);
      beats(6, 32'h0000_0200, 8'd7, 5, -1, -1);
      check("early_rlast_err", err, 1'b1);
      issue(32'h0000_0300, 1'b0, 32'h0000_0300, 8'd0, 0);
      beats(1, 32'h0000_0300, 8'd0, 0, -1, -1);
      check("err_sticky", err, 1'b1);

      // Reset clears err; SLVERR response sets it while data still flows.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("err_cleared", err, 1'b0);
      issue(32'h0000_0400, 1'b0, 32'h0000_0400, 8'd0, 0);
      beats(1, 32'h0000_0400, 8'd0, 0, -1, 0);
      check("rresp_err", err, 1'b1);

      // Reset in the middle of a burst (beat 4).
      issue(32'h0000_0500, 1'b1, 32'h0000_0500, 8'd7, 0);
      beats(3, 32'h0000_0500, 8'd7, 99, -1, -1);
      rvalid = 1'b1; rdata = 32'h0000_050C; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; rvalid = 1'b0;
      check("midrst_arvalid", arvalid, 1'b0);
      check("midrst_rready", rready, 1'b0);
      check("midrst_c_rvalid", c_rvalid, 1'b0);
      check("midrst_c_rlast", c_rlast, 1'b0);
      check("midrst_err", err, 1'b0);
      issue(32'h0000_0600, 1'b0, 32'h0000_0600, 8'd0, 0);
      beats(1, 32'h0000_0600, 8'd0, 0, -1, -1);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb_q.size(), 0);
      check("ar_empty", ar_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
